// File: rtl/ley_control_incremental.sv
// Velocity-form incremental control law u[n] = sat(u[n-1] + c0*e[n] + c1*e[n-1] + c2*e[n-2]).
// One external saturating multiplier is shared over three cycles (M0, M1, M2).
module ley_control_incremental #(
  parameter int Magnitud = 8,
  parameter int Decimal  = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                inicio,
  input  logic                                limpiar,
  input  logic [Magnitud+Decimal:0]           e_n,
  input  logic [Magnitud+Decimal:0]           c0,
  input  logic [Magnitud+Decimal:0]           c1,
  input  logic [Magnitud+Decimal:0]           c2,
  output logic [Magnitud+Decimal:0]           mult_a,
  output logic [Magnitud+Decimal:0]           mult_b,
  input  logic [Magnitud+Decimal:0]           mult_p,
  output logic [Magnitud+Decimal:0]           u_out,
  output logic                                listo,
  output logic                                ocupado,
  output logic                                saturado
);

  localparam int N = Magnitud + Decimal + 1;

  localparam logic        [N-1:0] MAXV    = {1'b0, {(N-1){1'b1}}};
  localparam logic        [N-1:0] MINV    = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic signed [N:0]   SUM_MAX = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0]   SUM_MIN = -SUM_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    M0   = 2'd1,
    M1   = 2'd2,
    M2   = 2'd3
  } state_t;

  state_t         state_q;
  logic [N-1:0]   e0_q, e1_q, e2_q;
  logic [N-1:0]   u_prev_q, acc_q, u_out_q;
  logic           listo_q, saturado_q, sat_tmp_q;

  logic [N-1:0]   add_lhs;
  logic signed [N:0] sum_d;
  logic [N-1:0]   acc_d;
  logic           clamp_d;

  // Operand steering and the single shared saturating adder.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mult_a  = '0;
    mult_b  = '0;
    add_lhs = acc_q;
    unique case (state_q)
      M0: begin
        mult_a  = c0;
        mult_b  = e0_q;
        add_lhs = u_prev_q;
      end
      M1: begin
        mult_a = c1;
        mult_b = e1_q;
      end
      M2: begin
        mult_a = c2;
        mult_b = e2_q;
      end
      default: ;
    endcase

    sum_d   = {add_lhs[N-1], add_lhs} + {mult_p[N-1], mult_p};
    clamp_d = 1'b0;
    acc_d   = sum_d[N-1:0];
    if (sum_d > SUM_MAX) begin
      acc_d   = MAXV;
      clamp_d = 1'b1;
    end else if (sum_d < SUM_MIN) begin
      // Symmetric range: -2^(N-1) is also clamped to MINV.
      acc_d   = MINV;
      clamp_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      e0_q       <= '0;
      e1_q       <= '0;
      e2_q       <= '0;
      u_prev_q   <= '0;
      acc_q      <= '0;
      u_out_q    <= '0;
      listo_q    <= 1'b0;
      saturado_q <= 1'b0;
      sat_tmp_q  <= 1'b0;
    end else if (limpiar) begin
      state_q    <= IDLE;
      e0_q       <= '0;
      e1_q       <= '0;
      e2_q       <= '0;
      u_prev_q   <= '0;
      acc_q      <= '0;
      u_out_q    <= '0;
      listo_q    <= 1'b0;
      saturado_q <= 1'b0;
      sat_tmp_q  <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (inicio) begin
            e0_q      <= e_n;
            sat_tmp_q <= 1'b0;
            state_q   <= M0;
          end
        end
        M0: begin
          acc_q     <= acc_d;
          sat_tmp_q <= sat_tmp_q | clamp_d;
          state_q   <= M1;
        end
        M1: begin
          acc_q     <= acc_d;
          sat_tmp_q <= sat_tmp_q | clamp_d;
          state_q   <= M2;
        end
        M2: begin
          u_out_q    <= acc_d;
          u_prev_q   <= acc_d;
          e2_q       <= e1_q;
          e1_q       <= e0_q;
          listo_q    <= 1'b1;
          saturado_q <= sat_tmp_q | clamp_d;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign u_out    = u_out_q;
  assign listo    = listo_q;
  assign saturado = saturado_q;
  assign ocupado  = (state_q != IDLE);

endmodule
